// File: rtl/render_pkg.sv
// Shared rendering types and screen constants.
// Used by the quad bounding-box scanner and its helpers.
package render_pkg;

  localparam int FRAC_BITS = 10;
  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;

  typedef logic signed [20:0] coord_q;
  typedef logic signed [10:0] pix_int;

  typedef enum logic [1:0] {
    IDLE,
    BBOX,
    CLIP,
    SCAN
  } scan_state_e;

endpackage

// File: rtl/min_max4.sv
// Combinational min and max of four signed integer pixel coordinates.
// Two-level compare tree, no state.
module min_max4
  import render_pkg::*;
(
  input  pix_int a,
  input  pix_int b,
  input  pix_int c,
  input  pix_int d,
  output pix_int mn,
  output pix_int mx
);

  pix_int mn_ab;
  pix_int mn_cd;
  pix_int mx_ab;
  pix_int mx_cd;

  assign mn_ab = (a < b) ? a : b;
  assign mn_cd = (c < d) ? c : d;
  assign mx_ab = (a > b) ? a : b;
  assign mx_cd = (c > d) ? c : d;

  assign mn = (mn_ab < mn_cd) ? mn_ab : mn_cd;
  assign mx = (mx_ab > mx_cd) ? mx_ab : mx_cd;

endmodule

// File: rtl/quad_bbox_scanner.sv
// Bounds a screen-space quad, clips the box to the screen and
// streams every covered pixel in row-major order.
module quad_bbox_scanner
  import render_pkg::*;
#(
  parameter int COORD_W = 21
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] vtx1_X,
  input  logic [COORD_W-1:0] vtx1_Y,
  input  logic [COORD_W-1:0] vtx2_X,
  input  logic [COORD_W-1:0] vtx2_Y,
  input  logic [COORD_W-1:0] vtx3_X,
  input  logic [COORD_W-1:0] vtx3_Y,
  input  logic [COORD_W-1:0] vtx4_X,
  input  logic [COORD_W-1:0] vtx4_Y,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [9:0]         pix_x,
  output logic [8:0]         pix_y,
  output logic               pix_last,
  output logic               busy
);

  localparam pix_int X_LIM = pix_int'(SCREEN_W - 1);
  localparam pix_int Y_LIM = pix_int'(SCREEN_H - 1);

  scan_state_e state_q, state_d;
  logic        in_ready_q, in_ready_d;
  coord_q      vx_q [4];
  coord_q      vx_d [4];
  coord_q      vy_q [4];
  coord_q      vy_d [4];
  pix_int      xmin_q, xmin_d, xmax_q, xmax_d;
  pix_int      ymin_q, ymin_d, ymax_q, ymax_d;
  logic [9:0]  pix_x_q, pix_x_d;
  logic [8:0]  pix_y_q, pix_y_d;

  pix_int ix [4];
  pix_int iy [4];
  pix_int bx_min, bx_max, by_min, by_max;
  pix_int cx_min, cx_max, cy_min, cy_max;
  logic   at_row_end;
  logic   at_end;

  // Floor of each Q11.10 coordinate via arithmetic shift.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ix[i] = pix_int'(vx_q[i] >>> FRAC_BITS);
      iy[i] = pix_int'(vy_q[i] >>> FRAC_BITS);
    end
  end

  min_max4 u_mm_x (
    .a (ix[0]),
    .b (ix[1]),
    .c (ix[2]),
    .d (ix[3]),
    .mn(bx_min),
    .mx(bx_max)
  );

  min_max4 u_mm_y (
    .a (iy[0]),
    .b (iy[1]),
    .c (iy[2]),
    .d (iy[3]),
    .mn(by_min),
    .mx(by_max)
  );

  assign cx_min = (xmin_q < 0) ? '0 : xmin_q;
  assign cy_min = (ymin_q < 0) ? '0 : ymin_q;
  assign cx_max = (xmax_q > X_LIM) ? X_LIM : xmax_q;
  assign cy_max = (ymax_q > Y_LIM) ? Y_LIM : ymax_q;

  assign at_row_end = (pix_x_q == xmax_q[9:0]);
  assign at_end     = at_row_end && (pix_y_q == ymax_q[8:0]);

  always_comb begin
    state_d = state_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    pix_x_d = pix_x_q;
    pix_y_d = pix_y_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          vx_d    = '{coord_q'(vtx1_X), coord_q'(vtx2_X),
                      coord_q'(vtx3_X), coord_q'(vtx4_X)};
          vy_d    = '{coord_q'(vtx1_Y), coord_q'(vtx2_Y),
                      coord_q'(vtx3_Y), coord_q'(vtx4_Y)};
          state_d = BBOX;
        end
      end
      BBOX: begin
        xmin_d  = bx_min;
        xmax_d  = bx_max;
        ymin_d  = by_min;
        ymax_d  = by_max;
        state_d = CLIP;
      end
      CLIP: begin
        if ((cx_min > cx_max) || (cy_min > cy_max)) begin
          state_d = IDLE;
        end else begin
          xmin_d  = cx_min;
          xmax_d  = cx_max;
          ymin_d  = cy_min;
          ymax_d  = cy_max;
          pix_x_d = cx_min[9:0];
          pix_y_d = cy_min[8:0];
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (pix_ready) begin
          if (at_end) begin
            state_d = IDLE;
          end else if (at_row_end) begin
            pix_x_d = xmin_q[9:0];
            pix_y_d = pix_y_q + 9'd1;
          end else begin
            pix_x_d = pix_x_q + 10'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      vx_q       <= '{default: '0};
      vy_q       <= '{default: '0};
      xmin_q     <= '0;
      xmax_q     <= '0;
      ymin_q     <= '0;
      ymax_q     <= '0;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      vx_q       <= vx_d;
      vy_q       <= vy_d;
      xmin_q     <= xmin_d;
      xmax_q     <= xmax_d;
      ymin_q     <= ymin_d;
      ymax_q     <= ymax_d;
      pix_x_q    <= pix_x_d;
      pix_y_q    <= pix_y_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign pix_valid = (state_q == SCAN);
  assign pix_last  = pix_valid && at_end;
  assign busy      = (state_q != IDLE);
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;

endmodule

// File: tb/tb_quad_bbox_scanner.sv
// Randomized and directed bench for quad_bbox_scanner against a
// pixel-list model built from floor/min/max/clamp arithmetic.
module tb_quad_bbox_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [20:0] v1x = '0, v1y = '0, v2x = '0, v2y = '0;
  logic [20:0] v3x = '0, v3y = '0, v4x = '0, v4y = '0;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        pix_last;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int vx [4];
  int vy [4];
  int rdy_cnt = 0;

  always #5 clk = ~clk;

  quad_bbox_scanner dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .vtx1_X   (v1x),
    .vtx1_Y   (v1y),
    .vtx2_X   (v2x),
    .vtx2_Y   (v2y),
    .vtx3_X   (v3x),
    .vtx3_Y   (v3y),
    .vtx4_X   (v4x),
    .vtx4_Y   (v4y),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .pix_last (pix_last),
    .busy     (busy)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit next_ready(input int mode);
    bit r;
    case (mode)
      0: r = 1'b1;
      1: r = (rdy_cnt % 3) == 0;
      default: r = 1'($urandom % 2);
    endcase
    rdy_cnt++;
    return r;
  endfunction

  // mode: 0 ready always, 1 pattern 1,0,0, 2 random.
  // abort_at: pixel index at which reset is pulsed, -1 for none.
  task automatic run_quad(input int mode, input int abort_at);
    int qx[$];
    int qy[$];
    int xmn, xmx, ymn, ymx;
    int k, popped;
    bit done, seen;
    xmn = vx[0] >>> 10; xmx = xmn;
    ymn = vy[0] >>> 10; ymx = ymn;
    for (int i = 1; i < 4; i++) begin
      if ((vx[i] >>> 10) < xmn) xmn = vx[i] >>> 10;
      if ((vx[i] >>> 10) > xmx) xmx = vx[i] >>> 10;
      if ((vy[i] >>> 10) < ymn) ymn = vy[i] >>> 10;
      if ((vy[i] >>> 10) > ymx) ymx = vy[i] >>> 10;
    end
    if (xmn < 0) xmn = 0;
    if (ymn < 0) ymn = 0;
    if (xmx > 639) xmx = 639;
    if (ymx > 479) ymx = 479;
    for (int y = ymn; y <= ymx; y++)
      for (int x = xmn; x <= xmx; x++) begin
        qx.push_back(x);
        qy.push_back(y);
      end
    v1x = vx[0][20:0]; v2x = vx[1][20:0];
    v3x = vx[2][20:0]; v4x = vx[3][20:0];
    v1y = vy[0][20:0]; v2y = vy[1][20:0];
    v3y = vy[2][20:0]; v4y = vy[3][20:0];
    in_valid = 1'b1;
    pix_ready = 1'b0;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("in_ready_idle", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    k = 0; popped = 0; done = 0; seen = 0;
    while (!done && k < 3000) begin
      if (pix_valid) begin
        if (!seen) chk("first_pix_latency", k, 2);
        seen = 1;
        chk("in_ready_scan", in_ready, 0);
        if (qx.size() == 0) begin
          chk("extra_pixel", 1, 0);
          done = 1;
        end else begin
          chk("pix_x", pix_x, qx[0]);
          chk("pix_y", pix_y, qy[0]);
          chk("pix_last", pix_last, int'(qx.size() == 1));
          if (popped == abort_at) begin
            rst_n = 1'b0;
            #1;
            chk("rst_pix_valid", pix_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_pix_last", pix_last, 0);
            chk("rst_in_ready", in_ready, 0);
            @(negedge clk);
            rst_n = 1'b1;
            pix_ready = 1'b0;
            @(negedge clk);
            chk("post_rst_in_ready", in_ready, 1);
            chk("post_rst_pix_valid", pix_valid, 0);
            return;
          end
          pix_ready = next_ready(mode);
          if (pix_ready) begin
            void'(qx.pop_front());
            void'(qy.pop_front());
            popped++;
          end
        end
      end else begin
        pix_ready = next_ready(mode);
        if (k == 1) chk("in_ready_bbox", in_ready, 0);
        if (seen || k >= 2) begin
          chk("pixels_left", qx.size(), 0);
          chk("in_ready_done", in_ready, 1);
          chk("busy_done", busy, 0);
          done = 1;
        end
      end
      @(negedge clk);
      k++;
    end
    if (!done) chk("timeout", 0, 1);
    pix_ready = 1'b0;
  endtask

  task automatic set_rect(input int x0, input int x1,
                          input int y0, input int y1);
    vx = '{x0, x1, x1, x0};
    vy = '{y0, y0, y1, y1};
  endtask

  initial begin
    #2;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_pix_valid", pix_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_pix_last", pix_last, 0);
    chk("reset_pix_x", pix_x, 0);
    chk("reset_pix_y", pix_y, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_release_in_ready", in_ready, 1);

    set_rect(32'h2800, 32'h3200, 32'h5000, 32'h5700);
    run_quad(0, -1);
    rdy_cnt = 0;
    run_quad(1, -1);

    vx = '{-3072, 2048, 2048, -3072};
    vy = '{0, 0, 0, 0};
    run_quad(0, -1);

    vx = '{700 * 1024, 700 * 1024, 700 * 1024, 700 * 1024};
    vy = '{32'h5000, 32'h5000, 32'h5000, 32'h5000};
    run_quad(0, -1);

    set_rect(638 * 1024, 650 * 1024, 479 * 1024, 500 * 1024);
    run_quad(0, -1);

    set_rect(100 * 1024 + 5, 100 * 1024 + 900,
             50 * 1024 + 1, 50 * 1024 + 1000);
    run_quad(2, -1);

    set_rect(32'h2800, 32'h3200, 32'h5000, 32'h5700);
    run_quad(0, 2);
    run_quad(0, -1);

    for (int n = 0; n < 25; n++) begin
      int bx, by;
      bx = int'($urandom_range(0, 690)) - 30;
      by = int'($urandom_range(0, 530)) - 30;
      for (int i = 0; i < 4; i++) begin
        vx[i] = (bx + int'($urandom_range(0, 6))) * 1024
                + int'($urandom_range(0, 1023));
        vy[i] = (by + int'($urandom_range(0, 6))) * 1024
                + int'($urandom_range(0, 1023));
      end
      run_quad(n % 3, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
